// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu execute stage: ALU ops, branch conditions,
// access sizes and the execute FSM state type.
package ceespu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_MOVB = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd2;
    localparam logic [2:0] BR_GE  = 3'd3;
    localparam logic [2:0] BR_LTU = 3'd4;
    localparam logic [2:0] BR_GEU = 3'd5;
    localparam logic [2:0] BR_CS  = 3'd6;
    localparam logic [2:0] BR_CC  = 3'd7;

    localparam logic [1:0] SZ_WORD  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_BYTE  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exe_state_t;

    // Number of byte lanes touched by an access of the given size.
    function automatic int unsigned size_lanes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE:  return 1;
            SZ_HALF:  return 2;
            SZ_WORD:  return 4;
            default:  return 8;
        endcase
    endfunction

endpackage

// File: rtl/ceespu_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles,
// low XLEN bits of the unsigned product. O_done stays high until next start/abort.
module ceespu_iter_mul #(
    parameter int XLEN = 32
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_start,
    input  logic            I_abort,
    input  logic [XLEN-1:0] I_a,
    input  logic [XLEN-1:0] I_b,
    output logic            O_done,
    output logic [XLEN-1:0] O_product
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   count;
    logic            running;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
            O_done  <= 1'b0;
        end else if (I_abort) begin
            running <= 1'b0;
            O_done  <= 1'b0;
            count   <= '0;
        end else if (I_start) begin
            acc     <= '0;
            mcand   <= I_a;
            mplier  <= I_b;
            count   <= CW'(XLEN);
            running <= 1'b1;
            O_done  <= 1'b0;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
                running <= 1'b0;
                O_done  <= 1'b1;
            end
        end
    end

    assign O_product = acc;

endmodule

// File: rtl/ceespu_execute_pl.sv
// Handshaked ceespu execute stage: ALU, address/store-lane generation,
// misalignment detection, branch resolution and an iterative multiplier.
module ceespu_execute_pl
    import ceespu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 14,
    parameter int REG_W = 5
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic                I_valid,
    output logic                O_ready,
    input  logic                I_stall,
    input  logic                I_flush,
    input  logic [3:0]          I_aluop,
    input  logic [XLEN-1:0]     I_dataA,
    input  logic [XLEN-1:0]     I_dataB,
    input  logic [XLEN-1:0]     I_storeData,
    input  logic [1:0]          I_selCin,
    input  logic                I_we,
    input  logic [REG_W-1:0]    I_regD,
    input  logic                I_memE,
    input  logic                I_memWe,
    input  logic [2:0]          I_selMem,
    input  logic                I_isBranch,
    input  logic                I_prediction,
    input  logic [2:0]          I_branchop,
    input  logic [PC_W-1:0]     I_PC,
    input  logic [PC_W-1:0]     I_branchTarget,
    output logic                O_valid,
    output logic [XLEN-1:0]     O_aluResult,
    output logic [XLEN-1:0]     O_StoreData,
    output logic [XLEN-1:0]     O_memAddress,
    output logic [XLEN/8-1:0]   O_memWe,
    output logic                O_memE,
    output logic                O_we,
    output logic                O_misaligned,
    output logic [REG_W-1:0]    O_regD,
    output logic [PC_W-1:0]     O_PC,
    output logic [2:0]          O_selMem,
    output logic                O_branch_taken,
    output logic                O_branch_mispredict,
    output logic [PC_W-1:0]     O_branchTarget,
    output logic                O_busy
);

    localparam int LANES = XLEN / 8;
    localparam int LW    = $clog2(LANES);
    localparam int SHW   = $clog2(XLEN);

    exe_state_t        state;
    logic              c_flag;
    logic              out_en;
    logic              cin;
    logic [XLEN:0]     sum_add;
    logic [XLEN:0]     sum_sub;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   alu_res;
    logic              alu_carry;
    logic              carry_op;
    logic [XLEN-1:0]   store_rep;
    logic [LANES-1:0]  lane_mask;
    logic [LANES-1:0]  we_mask;
    logic              mis;
    logic              cmp;
    logic              accept;
    logic              mul_start;
    logic              mul_done;
    logic [XLEN-1:0]   mul_product;
    logic              pend_we;
    logic [REG_W-1:0]  pend_regD;
    logic [PC_W-1:0]   pend_PC;
    logic [SHW-1:0]    shamt;
    int unsigned       nl;
    int unsigned       li;
    logic [63:0]       mask_full;

    // out_en keeps the stage closed until the first edge after reset release.
    assign O_ready   = (state == ST_IDLE) && out_en && !I_stall;
    assign O_busy    = (state == ST_MUL);
    assign accept    = I_valid && O_ready && !I_flush;
    assign mul_start = accept && (I_aluop == OP_MUL);

    always_comb begin
        case (I_selCin)
            2'd0:    cin = 1'b0;
            2'd1:    cin = c_flag;
            2'd2:    cin = !c_flag;
            default: cin = 1'b1;
        endcase
    end

    assign sum_add = {1'b0, I_dataA} + {1'b0, I_dataB} + {{XLEN{1'b0}}, cin};
    assign sum_sub = {1'b0, I_dataA} + {1'b0, ~I_dataB} + {{XLEN{1'b0}}, cin};
    assign addr    = sum_add[XLEN-1:0];
    assign shamt   = I_dataB[SHW-1:0];
    assign carry_op = (I_aluop == OP_ADD) || (I_aluop == OP_SUB) ||
                      (I_aluop == OP_ADC) || (I_aluop == OP_SBC);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (I_aluop)
            OP_ADD, OP_ADC: begin
                alu_res   = sum_add[XLEN-1:0];
                alu_carry = sum_add[XLEN];
            end
            OP_SUB, OP_SBC: begin
                alu_res   = sum_sub[XLEN-1:0];
                alu_carry = sum_sub[XLEN];
            end
            OP_AND:  alu_res = I_dataA & I_dataB;
            OP_OR:   alu_res = I_dataA | I_dataB;
            OP_XOR:  alu_res = I_dataA ^ I_dataB;
            OP_SLL:  alu_res = I_dataA << shamt;
            OP_SRL:  alu_res = I_dataA >> shamt;
            OP_SRA:  alu_res = $signed(I_dataA) >>> shamt;
            OP_SLT:  alu_res = XLEN'($signed(I_dataA) < $signed(I_dataB));
            OP_SLTU: alu_res = XLEN'(I_dataA < I_dataB);
            OP_MOVB: alu_res = I_dataB;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        store_rep = I_storeData;
        case (I_selMem[1:0])
            SZ_BYTE: store_rep = {LANES{I_storeData[7:0]}};
            SZ_HALF: store_rep = {(LANES/2){I_storeData[15:0]}};
            SZ_WORD: store_rep = {(LANES/4){I_storeData[31:0]}};
            default: store_rep = I_storeData;
        endcase
    end

    // Lane mask: n contiguous lanes starting at the address rounded down to n.
    always_comb begin
        nl        = size_lanes(I_selMem[1:0]);
        li        = 32'(addr[LW-1:0]);
        mask_full = ((64'd1 << nl) - 64'd1) << (li & ~(nl - 1));
        lane_mask = mask_full[LANES-1:0];
    end

    always_comb begin
        case (I_selMem[1:0])
            SZ_HALF:  mis = addr[0];
            SZ_WORD:  mis = |addr[1:0];
            SZ_DWORD: mis = (XLEN == 32) ? 1'b1 : |addr[2:0];
            default:  mis = 1'b0;
        endcase
    end

    assign we_mask = (I_memE && I_memWe && !mis) ? lane_mask : '0;

    always_comb begin
        case (I_branchop)
            BR_EQ:   cmp = (I_dataA == I_dataB);
            BR_NE:   cmp = (I_dataA != I_dataB);
            BR_LT:   cmp = ($signed(I_dataA) < $signed(I_dataB));
            BR_GE:   cmp = ($signed(I_dataA) >= $signed(I_dataB));
            BR_LTU:  cmp = (I_dataA < I_dataB);
            BR_GEU:  cmp = (I_dataA >= I_dataB);
            BR_CS:   cmp = c_flag;
            default: cmp = !c_flag;
        endcase
    end

    assign O_branch_taken      = I_valid && I_isBranch && cmp;
    assign O_branch_mispredict = I_valid && I_isBranch && (O_branch_taken != I_prediction);
    assign O_branchTarget      = I_prediction ? (I_PC + PC_W'(1)) : I_branchTarget;

    ceespu_iter_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_start   (mul_start),
        .I_abort   (I_flush),
        .I_a       (I_dataA),
        .I_b       (I_dataB),
        .O_done    (mul_done),
        .O_product (mul_product)
    );

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state        <= ST_IDLE;
            c_flag       <= 1'b0;
            out_en       <= 1'b0;
            O_valid      <= 1'b0;
            O_aluResult  <= '0;
            O_StoreData  <= '0;
            O_memAddress <= '0;
            O_memWe      <= '0;
            O_memE       <= 1'b0;
            O_we         <= 1'b0;
            O_misaligned <= 1'b0;
            O_regD       <= '0;
            O_PC         <= '0;
            O_selMem     <= '0;
            pend_we      <= 1'b0;
            pend_regD    <= '0;
            pend_PC      <= '0;
        end else begin
            out_en <= 1'b1;
            if (I_flush) begin
                state   <= ST_IDLE;
                O_valid <= 1'b0;
                O_we    <= 1'b0;
                O_memE  <= 1'b0;
                O_memWe <= '0;
            end else if (state == ST_IDLE) begin
                if (accept) begin
                    if (carry_op) begin
                        c_flag <= alu_carry;
                    end
                    if (I_aluop == OP_MUL) begin
                        state     <= ST_MUL;
                        O_valid   <= 1'b0;
                        pend_we   <= I_we;
                        pend_regD <= I_regD;
                        pend_PC   <= I_PC;
                    end else begin
                        O_valid      <= 1'b1;
                        O_aluResult  <= alu_res;
                        O_StoreData  <= store_rep;
                        O_memAddress <= addr;
                        O_memWe      <= we_mask;
                        O_memE       <= I_memE && !mis;
                        O_misaligned <= I_memE && mis;
                        O_we         <= I_we;
                        O_regD       <= I_regD;
                        O_PC         <= I_PC;
                        O_selMem     <= I_selMem;
                    end
                end else if (!I_stall) begin
                    O_valid <= 1'b0;
                end
            end else begin
                // Product is written only once downstream can take it.
                if (mul_done && !I_stall) begin
                    state        <= ST_IDLE;
                    O_valid      <= 1'b1;
                    O_aluResult  <= mul_product;
                    O_StoreData  <= '0;
                    O_memAddress <= '0;
                    O_memWe      <= '0;
                    O_memE       <= 1'b0;
                    O_misaligned <= 1'b0;
                    O_we         <= pend_we;
                    O_regD       <= pend_regD;
                    O_PC         <= pend_PC;
                    O_selMem     <= '0;
                end else if (!I_stall) begin
                    O_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ceespu_execute_pl.sv
// Directed self-checking bench for ceespu_execute_pl at XLEN=32 and XLEN=64.
module tb_ceespu_execute_pl;
    import ceespu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid, stall, flush, we, memE, memWe, isBranch, prediction;
    logic [3:0]  aluop;
    logic [63:0] A, B, SD;
    logic [1:0]  selCin;
    logic [4:0]  regD;
    logic [2:0]  selMem, branchop;
    logic [13:0] pc, btgt;

    logic        rdy32, val32, memE32, we32, mis32, tk32, mp32, busy32;
    logic [31:0] res32, sd32, addr32;
    logic [3:0]  mwe32;
    logic [4:0]  regD32;
    logic [13:0] pc32, bt32;
    logic [2:0]  sel32;

    logic        rdy64, val64, memE64, we64, mis64, tk64, mp64, busy64;
    logic [63:0] res64, sd64, addr64;
    logic [7:0]  mwe64;
    logic [4:0]  regD64;
    logic [13:0] pc64, bt64;
    logic [2:0]  sel64;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ceespu_execute_pl #(.XLEN(32), .PC_W(14), .REG_W(5)) u32 (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .O_ready(rdy32), .I_stall(stall),
        .I_flush(flush), .I_aluop(aluop), .I_dataA(A[31:0]), .I_dataB(B[31:0]),
        .I_storeData(SD[31:0]), .I_selCin(selCin), .I_we(we), .I_regD(regD),
        .I_memE(memE), .I_memWe(memWe), .I_selMem(selMem), .I_isBranch(isBranch),
        .I_prediction(prediction), .I_branchop(branchop), .I_PC(pc),
        .I_branchTarget(btgt), .O_valid(val32), .O_aluResult(res32),
        .O_StoreData(sd32), .O_memAddress(addr32), .O_memWe(mwe32), .O_memE(memE32),
        .O_we(we32), .O_misaligned(mis32), .O_regD(regD32), .O_PC(pc32),
        .O_selMem(sel32), .O_branch_taken(tk32), .O_branch_mispredict(mp32),
        .O_branchTarget(bt32), .O_busy(busy32)
    );

    ceespu_execute_pl #(.XLEN(64), .PC_W(14), .REG_W(5)) u64 (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .O_ready(rdy64), .I_stall(stall),
        .I_flush(flush), .I_aluop(aluop), .I_dataA(A), .I_dataB(B),
        .I_storeData(SD), .I_selCin(selCin), .I_we(we), .I_regD(regD),
        .I_memE(memE), .I_memWe(memWe), .I_selMem(selMem), .I_isBranch(isBranch),
        .I_prediction(prediction), .I_branchop(branchop), .I_PC(pc),
        .I_branchTarget(btgt), .O_valid(val64), .O_aluResult(res64),
        .O_StoreData(sd64), .O_memAddress(addr64), .O_memWe(mwe64), .O_memE(memE64),
        .O_we(we64), .O_misaligned(mis64), .O_regD(regD64), .O_PC(pc64),
        .O_selMem(sel64), .O_branch_taken(tk64), .O_branch_mispredict(mp64),
        .O_branchTarget(bt64), .O_busy(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid = 0; stall = 0; flush = 0; we = 0; memE = 0; memWe = 0;
        isBranch = 0; prediction = 0; aluop = OP_ADD; A = '0; B = '0; SD = '0;
        selCin = 2'd0; regD = '0; selMem = 3'd0; branchop = BR_EQ; pc = '0; btgt = '0;
    endtask

    initial begin
        quiet();
        #3;
        chk("rst_valid", val32, 0);
        chk("rst_ready", rdy32, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_result", res32, 0);
        rst = 1'b1;
        tick();
        chk("ready_after_rst", rdy32, 1);

        // ADD sets carry, ADC consumes it
        valid = 1; we = 1; regD = 5'd3; aluop = OP_ADD; A = 64'hFFFF_FFFF; B = 64'd1;
        tick();
        chk("add_valid", val32, 1);
        chk("add_result", res32, 0);
        chk("add_regD", regD32, 3);
        aluop = OP_ADC; A = 0; B = 0; selCin = 2'd1;
        tick();
        chk("adc_result", res32, 1);
        chk("adc_addr", addr32, 1);
        chk("adc_memWe", mwe32, 0);
        aluop = OP_SUB; A = 5; B = 3; selCin = 2'd3;
        tick();
        chk("sub_result", res32, 2);
        aluop = OP_XOR; A = 64'hF0F0; B = 64'h0FF0; selCin = 2'd0;
        tick();
        chk("xor_result", res32, 64'hFF00);

        // stores
        aluop = OP_ADD; memE = 1; memWe = 1; we = 0;
        A = 64'h1000; B = 2; selMem = {1'b0, SZ_BYTE}; SD = 64'hAB;
        tick();
        chk("byte_sd32", sd32, 64'hABAB_ABAB);
        chk("byte_we32", mwe32, 4'b0100);
        chk("byte_memE32", memE32, 1);
        chk("byte_sd64", sd64, 64'hABAB_ABAB_ABAB_ABAB);
        chk("byte_we64", mwe64, 8'h04);
        B = 1; selMem = {1'b0, SZ_HALF}; SD = 64'h1234;
        tick();
        chk("half_mis", mis32, 1);
        chk("half_we", mwe32, 0);
        chk("half_memE", memE32, 0);
        chk("half_sd", sd32, 64'h1234_1234);
        B = 4; selMem = {1'b0, SZ_WORD}; SD = 64'h1122_3344;
        tick();
        chk("word_we32", mwe32, 4'hF);
        chk("word_mis32", mis32, 0);
        chk("word_we64", mwe64, 8'hF0);
        chk("word_sd64", sd64, 64'h1122_3344_1122_3344);
        memE = 0; memWe = 0; selMem = 3'd0;

        // branch resolution under stall; outputs must hold
        stall = 1; isBranch = 1; branchop = BR_EQ; A = 7; B = 7;
        prediction = 0; pc = 14'h3FFF; btgt = 14'h0100;
        #1;
        chk("stall_ready", rdy32, 0);
        chk("br_taken", tk32, 1);
        chk("br_mispredict", mp32, 1);
        chk("br_target", bt32, 14'h0100);
        prediction = 1;
        #1;
        chk("br_target_wrap", bt32, 14'h0000);
        chk("br_pred_ok", mp32, 0);
        B = 8;
        #1;
        chk("br_not_taken", tk32, 0);
        tick();
        chk("stall_hold_valid", val32, 1);
        chk("stall_hold_result", res32, 64'h1004);
        quiet();
        tick();
        chk("idle_valid", val32, 0);

        // multiply, no stall
        valid = 1; we = 1; regD = 5'd7; aluop = OP_MUL; A = 1234; B = 5678;
        tick();
        quiet();
        chk("mul_busy0", busy32, 1);
        chk("mul_ready0", rdy32, 0);
        chk("mul_valid0", val32, 0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 32) begin
                chk("mul_busy32", busy32, 1);
                chk("mul_valid32", val32, 0);
            end
        end
        tick();
        chk("mul_valid33", val32, 1);
        chk("mul_result", res32, 64'd7006652);
        chk("mul_we", we32, 1);
        chk("mul_regD", regD32, 7);
        chk("mul_busy33", busy32, 0);
        tick();
        chk("mul_valid_drop", val32, 0);

        // multiply with stall at completion
        valid = 1; aluop = OP_MUL; A = 64'hFFFF_FFFF; B = 64'hFFFF_FFFF;
        tick();
        quiet();
        for (int i = 1; i <= 32; i++) tick();
        stall = 1;
        for (int i = 33; i <= 35; i++) tick();
        chk("mulst_valid35", val32, 0);
        chk("mulst_busy35", busy32, 1);
        stall = 0;
        tick();
        chk("mulst_valid36", val32, 1);
        chk("mulst_result", res32, 1);

        // flush during multiply
        valid = 1; aluop = OP_MUL; A = 3; B = 9;
        tick();
        quiet();
        for (int i = 1; i <= 10; i++) tick();
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("flush_busy", busy32, 0);
        chk("flush_valid", val32, 0);
        chk("flush_ready", rdy32, 1);
        tick();
        chk("flush_valid_after", val32, 0);

        // flush on the final iteration edge
        valid = 1; aluop = OP_MUL; A = 3; B = 9;
        tick();
        quiet();
        for (int i = 1; i <= 31; i++) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flushlast_busy", busy32, 0);
        chk("flushlast_valid", val32, 0);
        tick();
        chk("flushlast_valid_after", val32, 0);

        // flush over a single-cycle result
        valid = 1; we = 1; aluop = OP_ADD; A = 3; B = 4;
        tick();
        chk("pre_flush_result", res32, 7);
        flush = 1;
        tick();
        flush = 0;
        chk("flush1_valid", val32, 0);
        chk("flush1_we", we32, 0);

        // dword store
        valid = 1; we = 1; regD = 5'd9; aluop = OP_ADD; A = 8; B = 0;
        memE = 1; memWe = 1; selMem = {1'b0, SZ_DWORD}; SD = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("dword_we64", mwe64, 8'hFF);
        chk("dword_mis64", mis64, 0);
        chk("dword_sd64", sd64, 64'h0123_4567_89AB_CDEF);
        chk("dword_mis32", mis32, 1);
        chk("dword_we32", mwe32, 0);

        // asynchronous reset in the middle of a multiply
        quiet();
        valid = 1; aluop = OP_MUL; A = 3; B = 5;
        tick();
        quiet();
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy32, 0);
        chk("arst_valid", val32, 0);
        chk("arst_result", res32, 0);
        chk("arst_regD", regD32, 0);
        chk("arst_ready", rdy32, 0);
        chk("arst_we64", mwe64, 0);
        chk("arst_busy64", busy64, 0);
        rst = 1'b1;
        tick();
        chk("arst_ready_after", rdy32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
